// File: rtl/mac_array_ctrl_if.sv
// Handshake and array-facing bus of the mac_array job sequencer.
// slave  : the sequencer (accepts jobs/operands, drives the array, offers results).
// master : the surrounding environment (job source, operand source, array, result sink).
interface mac_array_ctrl_if #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int ROW_SIZE     = 4,
  parameter int COLUMN_SIZE  = 4
);
  logic                                job_valid;
  logic                                job_ready;
  logic [NUM_WIDTH-1:0]                job_k;
  logic                                op_valid;
  logic                                op_ready;
  logic [ROW_SIZE*MULER_WIDTH-1:0]     op_a;
  logic [COLUMN_SIZE*MULER_WIDTH-1:0]  op_b;
  logic                                arr_num_valid;
  logic [NUM_WIDTH-1:0]                arr_num;
  logic [ROW_SIZE*MULER_WIDTH-1:0]     arr_data_a;
  logic [COLUMN_SIZE*MULER_WIDTH-1:0]  arr_data_b;
  logic [COLUMN_SIZE*OUTPUT_WIDTH-1:0] arr_result;
  logic                                res_valid;
  logic                                res_ready;
  logic [COLUMN_SIZE*OUTPUT_WIDTH-1:0] res_data;
  logic                                busy;

  modport slave (
    input  job_valid, job_k, op_valid, op_a, op_b, arr_result, res_ready,
    output job_ready, op_ready, arr_num_valid, arr_num, arr_data_a, arr_data_b,
           res_valid, res_data, busy
  );

  modport master (
    output job_valid, job_k, op_valid, op_a, op_b, arr_result, res_ready,
    input  job_ready, op_ready, arr_num_valid, arr_num, arr_data_a, arr_data_b,
           res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Job sequencer for mac_array: accepts a reduction length K, loads it into the
// array, streams K operand beats (zero bubbles on upstream stalls), waits for
// the array pipeline to drain, then offers the captured result vector.
// Optional build macro MAC_CTRL_PERF_EN adds perf_cycles / perf_bubbles counters.
module mac_array_ctrl #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int ROW_SIZE     = 4,
  parameter int COLUMN_SIZE  = 4,
  parameter int MULER_DELAY  = 1,
  parameter int DRAIN_CYCLES = ROW_SIZE + COLUMN_SIZE + MULER_DELAY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_array_ctrl_if.slave      bus
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_bubbles
`endif
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                              r_state;
  state_t                              w_next_state;
  logic [NUM_WIDTH-1:0]                r_k;
  logic [NUM_WIDTH-1:0]                r_beat_cnt;
  logic [DCW-1:0]                      r_drain_cnt;
  logic [COLUMN_SIZE*OUTPUT_WIDTH-1:0] r_res_data;
  logic                                w_last_beat;
  logic                                w_drain_done;

  // beat_cnt never exceeds k_reg-1 before this add, so K = 2^NUM_WIDTH-1 cannot wrap
  assign w_last_beat  = bus.op_valid && ((r_beat_cnt + NUM_WIDTH'(1)) == r_k);
  assign w_drain_done = (r_drain_cnt == DCW'(DRAIN_CYCLES - 1));

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.job_valid) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: begin
        if (r_k == {NUM_WIDTH{1'b0}}) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_beat) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_next_state = S_OUT;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_OUT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job length, beat/drain counters and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k         <= {NUM_WIDTH{1'b0}};
      r_beat_cnt  <= {NUM_WIDTH{1'b0}};
      r_drain_cnt <= {DCW{1'b0}};
      r_res_data  <= {(COLUMN_SIZE*OUTPUT_WIDTH){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.job_valid) begin
            r_k         <= bus.job_k;
            r_beat_cnt  <= {NUM_WIDTH{1'b0}};
            r_drain_cnt <= {DCW{1'b0}};
          end
        end
        S_STREAM: begin
          if (bus.op_valid) begin
            r_beat_cnt <= r_beat_cnt + NUM_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_res_data  <= bus.arr_result;
            r_drain_cnt <= {DCW{1'b0}};
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        default: begin
          r_beat_cnt <= r_beat_cnt;
        end
      endcase
    end
  end

  // Outputs decoded from the state register; operand data passes through in STREAM
  always_comb begin
    bus.job_ready     = 1'b0;
    bus.op_ready      = 1'b0;
    bus.arr_num_valid = 1'b0;
    bus.arr_num       = {NUM_WIDTH{1'b0}};
    bus.arr_data_a    = {(ROW_SIZE*MULER_WIDTH){1'b0}};
    bus.arr_data_b    = {(COLUMN_SIZE*MULER_WIDTH){1'b0}};
    bus.res_valid     = 1'b0;
    bus.res_data      = r_res_data;
    bus.busy          = 1'b0;
    if (r_state == S_IDLE) begin
      bus.job_ready = 1'b1;
    end else begin
      bus.busy    = 1'b1;
      bus.arr_num = r_k;
    end
    if (r_state == S_LOAD) begin
      bus.arr_num_valid = 1'b1;
    end else begin
      bus.arr_num_valid = 1'b0;
    end
    if (r_state == S_STREAM) begin
      bus.op_ready = 1'b1;
      if (bus.op_valid) begin
        bus.arr_data_a = bus.op_a;
        bus.arr_data_b = bus.op_b;
      end else begin
        bus.arr_data_a = {(ROW_SIZE*MULER_WIDTH){1'b0}};
        bus.arr_data_b = {(COLUMN_SIZE*MULER_WIDTH){1'b0}};
      end
    end else begin
      bus.op_ready = 1'b0;
    end
    if (r_state == S_OUT) begin
      bus.res_valid = 1'b1;
    end else begin
      bus.res_valid = 1'b0;
    end
  end

`ifdef MAC_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_bubbles;

  assign perf_cycles  = r_perf_cycles;
  assign perf_bubbles = r_perf_bubbles;

  // Per-job saturating counters: clear on accept, hold once the job is back in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles  <= 32'd0;
      r_perf_bubbles <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (bus.job_valid) begin
        r_perf_cycles  <= 32'd0;
        r_perf_bubbles <= 32'd0;
      end
    end else begin
      if (r_perf_cycles != 32'hFFFF_FFFF) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == S_STREAM) && !bus.op_valid && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: directed jobs plus randomized jobs,
// checked cycle by cycle against a job timeline computed inside the bench.
module tb_mac_array_ctrl;
  localparam int MW = 8;
  localparam int NW = 16;
  localparam int OW = 32;
  localparam int RS = 4;
  localparam int CS = 4;
  localparam int MD = 1;
  localparam int D  = RS + CS + MD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mac_array_ctrl_if #(.MULER_WIDTH(MW), .NUM_WIDTH(NW), .OUTPUT_WIDTH(OW),
                      .ROW_SIZE(RS), .COLUMN_SIZE(CS)) bus ();
`ifdef MAC_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_bubbles;
`endif

  mac_array_ctrl #(.MULER_WIDTH(MW), .NUM_WIDTH(NW), .OUTPUT_WIDTH(OW),
                   .ROW_SIZE(RS), .COLUMN_SIZE(CS), .MULER_DELAY(MD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MAC_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_job_ready"}, bus.job_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_op_ready"}, bus.op_ready, 1'b0);
    chk({tag, "_res_valid"}, bus.res_valid, 1'b0);
    chk({tag, "_num_valid"}, bus.arr_num_valid, 1'b0);
    chk({tag, "_arr_num"}, bus.arr_num, 16'd0);
    chk({tag, "_data_a"}, bus.arr_data_a, 32'd0);
    chk({tag, "_data_b"}, bus.arr_data_b, 32'd0);
  endtask

  // One complete job from the accept cycle through the result handshake.
  // stall_mode: 0 none, 1 alternate (valid first), 2 random.
  task automatic run_job(input int k, input int stall_mode, input bit ident,
                         input int rdy_wait, input bit keep_valid, input int next_k);
    logic [127:0] cap;
    logic [31:0]  a;
    logic [31:0]  b;
    int cyc;
    int bub;
    int beats;
    int guard;
    bit v;
    // accept cycle
    bus.job_valid  = 1'b1;
    bus.job_k      = 16'(k);
    bus.op_valid   = 1'($urandom % 2);
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
    bus.res_ready  = 1'($urandom % 2);
    bus.arr_result = rnd128();
    settle();
    chk("acc_job_ready", bus.job_ready, 1'b1);
    chk("acc_busy", bus.busy, 1'b0);
    chk("acc_op_ready", bus.op_ready, 1'b0);
    chk("acc_arr_num", bus.arr_num, 16'd0);
    tick();
    if (keep_valid) bus.job_k = 16'(next_k);
    else bus.job_valid = 1'b0;
    // load cycle
    bus.op_valid = 1'b1;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    settle();
    chk("load_num_valid", bus.arr_num_valid, 1'b1);
    chk("load_arr_num", bus.arr_num, 16'(k));
    chk("load_data_a", bus.arr_data_a, 32'd0);
    chk("load_data_b", bus.arr_data_b, 32'd0);
    chk("load_op_ready", bus.op_ready, 1'b0);
    chk("load_job_ready", bus.job_ready, 1'b0);
    chk("load_busy", bus.busy, 1'b1);
    tick();
    cyc = 1;
    bub = 0;
    beats = 0;
    guard = 0;
    // operand stream
    while (beats < k && guard < 8 * k + 100) begin
      case (stall_mode)
        1:       v = (guard % 2 == 0);
        2:       v = ($urandom % 3 != 0);
        default: v = 1'b1;
      endcase
      if (ident) begin
        a = 32'h1 << (8 * (beats % RS));
        b = 32'h1 << (8 * (beats % CS));
      end else begin
        a = $urandom;
        b = $urandom;
      end
      bus.op_valid   = v;
      bus.op_a       = a;
      bus.op_b       = b;
      bus.arr_result = rnd128();
      settle();
      chk("st_op_ready", bus.op_ready, 1'b1);
      chk("st_num_valid", bus.arr_num_valid, 1'b0);
      chk("st_arr_num", bus.arr_num, 16'(k));
      chk("st_data_a", bus.arr_data_a, v ? a : 32'd0);
      chk("st_data_b", bus.arr_data_b, v ? b : 32'd0);
      chk("st_res_valid", bus.res_valid, 1'b0);
      if (v) beats++;
      else bub++;
      cyc++;
      guard++;
      tick();
    end
    if (beats < k) chk("stream_timeout", 128'(beats), 128'(k));
    // drain: array still computing, nothing passes through
    for (int i = 0; i < D; i++) begin
      bus.op_valid   = 1'($urandom % 2);
      bus.op_a       = $urandom;
      bus.op_b       = $urandom;
      bus.arr_result = rnd128();
      cap = bus.arr_result;
      settle();
      chk("dr_op_ready", bus.op_ready, 1'b0);
      chk("dr_data_a", bus.arr_data_a, 32'd0);
      chk("dr_data_b", bus.arr_data_b, 32'd0);
      chk("dr_res_valid", bus.res_valid, 1'b0);
      chk("dr_busy", bus.busy, 1'b1);
      chk("dr_arr_num", bus.arr_num, 16'(k));
      cyc++;
      tick();
    end
    // result offered; value must be the one present on the last drain cycle
    for (int w = 0; w <= rdy_wait; w++) begin
      bus.op_valid   = 1'b0;
      bus.res_ready  = (w == rdy_wait);
      bus.arr_result = rnd128();
      settle();
      chk("out_res_valid", bus.res_valid, 1'b1);
      chk("out_res_data", bus.res_data, cap);
      chk("out_job_ready", bus.job_ready, 1'b0);
      chk("out_busy", bus.busy, 1'b1);
      chk("out_num_valid", bus.arr_num_valid, 1'b0);
      cyc++;
      tick();
    end
    bus.res_ready = 1'b0;
`ifdef MAC_CTRL_PERF_EN
    settle();
    chk("perf_cycles", perf_cycles, 32'(cyc));
    chk("perf_bubbles", perf_bubbles, 32'(bub));
`endif
  endtask

  initial begin
    int rk;
    bus.job_valid  = 1'b0;
    bus.job_k      = 16'd0;
    bus.op_valid   = 1'b0;
    bus.op_a       = 32'd0;
    bus.op_b       = 32'd0;
    bus.res_ready  = 1'b0;
    bus.arr_result = 128'd0;
    rst_n = 1'b0;
    tick();
    tick();
    settle();
    chk_idle("reset");
    chk("reset_res_data", bus.res_data, 128'd0);
`ifdef MAC_CTRL_PERF_EN
    chk("reset_perf_cycles", perf_cycles, 32'd0);
    chk("reset_perf_bubbles", perf_bubbles, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // identity beats, no stalls
    run_job(4, 0, 1'b1, 0, 1'b0, 0);
    // alternate stalls
    run_job(4, 1, 1'b0, 0, 1'b0, 0);
    // empty job
    run_job(0, 0, 1'b0, 0, 1'b0, 0);
    // downstream holds off 10 cycles while a new job waits
    run_job(3, 2, 1'b0, 10, 1'b1, 5);
    run_job(5, 2, 1'b0, 0, 1'b0, 0);

    // reset after two of four beats
    bus.job_valid = 1'b1;
    bus.job_k     = 16'd4;
    tick();
    bus.job_valid = 1'b0;
    tick();
    bus.op_valid = 1'b1;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.op_valid = 1'b1;
    settle();
    chk_idle("rst_mid");
    chk("rst_mid_res_data", bus.res_data, 128'd0);
`ifdef MAC_CTRL_PERF_EN
    chk("rst_mid_perf_cycles", perf_cycles, 32'd0);
`endif
    run_job(2, 0, 1'b0, 0, 1'b0, 0);

    // back-to-back with job_valid held
    run_job(1, 0, 1'b0, 0, 1'b1, 3);
    run_job(3, 0, 1'b0, 0, 1'b0, 0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      rk = int'($urandom_range(0, 20));
      run_job(rk, 2, 1'b0, int'($urandom_range(0, 3)), 1'b0, 0);
    end

    bus.job_valid = 1'b0;
    bus.op_valid  = 1'b0;
    tick();
    settle();
    chk_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
Job sequencer for mac_array. It accepts a job descriptor (reduction length K), loads K into the array via num/num_valid, and streams K operand beats from an upstream source into data_a/data_b. When upstream stalls it inserts zero bubbles. It then drains the array pipeline and hands the captured result vector downstream through a valid/ready handshake.

Parameters:
MULER_WIDTH, 8, operand element width
NUM_WIDTH, 16, width of K
OUTPUT_WIDTH, 32, result element width
ROW_SIZE, 4, elements per data_a beat
COLUMN_SIZE, 4, elements per data_b beat and per result vector
MULER_DELAY, 1, multiplier pipeline depth in the array
DRAIN_CYCLES, ROW_SIZE+COLUMN_SIZE+MULER_DELAY, wait after the last operand before capture

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  controller can accept a job
job_k  in  NUM_WIDTH  reduction length K
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted
op_a  in  ROW_SIZE*MULER_WIDTH  A column beat
op_b  in  COLUMN_SIZE*MULER_WIDTH  B row beat
arr_num_valid  out  1  to mac_array num_valid
arr_num  out  NUM_WIDTH  to mac_array num
arr_data_a  out  ROW_SIZE*MULER_WIDTH  to mac_array data_a
arr_data_b  out  COLUMN_SIZE*MULER_WIDTH  to mac_array data_b
arr_result  in  COLUMN_SIZE*OUTPUT_WIDTH  from mac_array result_r
res_valid  out  1  result vector valid
res_ready  in  1  downstream accepts result
res_data  out  COLUMN_SIZE*OUTPUT_WIDTH  captured result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0 except job_ready=1. Counters are cleared. Reset mid-job aborts the job, and any partial result is discarded.
- IDLE: job_ready=1. On job_valid&job_ready, latch K into k_reg and go to LOAD.
- LOAD (1 cycle): arr_num_valid=1, arr_num=k_reg, arr_data_a/b=0. Next state is STREAM, or DRAIN if k_reg==0.
- STREAM:
  - op_ready=1.
  - On op_valid: drive arr_data_a=op_a, arr_data_b=op_b in the same cycle (combinational pass-through) and increment beat_cnt.
  - On !op_valid: drive zeros (bubble). beat_cnt holds.
  - When the accepted beat makes beat_cnt==k_reg, go to DRAIN. op_ready is 0 from the next cycle.
- DRAIN:
  - Drive zeros and count DRAIN_CYCLES cycles.
  - On the final count, register arr_result into res_data and go to OUT.
- OUT:
  - res_valid=1 and res_data is held stable until res_ready.
  - On res_valid&res_ready, go to IDLE. job_ready returns to 1 in the following cycle; there is no same-cycle job accept.
- Handshakes:
  - Upstream data must not be used unless valid&ready.
  - res_valid, once high, stays high until accepted.
- Widths: beat_cnt is NUM_WIDTH bits. The drain counter is $clog2(DRAIN_CYCLES+1) bits. K=2^NUM_WIDTH-1 must complete without wrap.
- arr_num_valid is high in LOAD only. arr_num holds k_reg in all non-IDLE states and is 0 in IDLE.
- job_valid while busy: ignored, since job_ready=0.

Optional Feature:
MAC_CTRL_PERF_EN:
- Defined: adds ports perf_cycles (out, 32) and perf_bubbles (out, 32).
  - Both clear on job accept.
  - perf_cycles counts every non-IDLE cycle of the current job.
  - perf_bubbles counts STREAM cycles with op_valid=0.
  - Both hold after the job ends and saturate at 2^32-1.
  - Both reset to 0.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- K=4, identity beats (a_i=b_i=one-hot lane i), no stalls, res_ready=1 -> arr_num_valid is a 1-cycle pulse with arr_num=4. Exactly 4 beats are passed through. res_valid asserts DRAIN_CYCLES+1 cycles after the last beat. res_data equals arr_result as sampled at capture.
- K=4 with op_valid low on alternate cycles -> zeros driven on stall cycles. Exactly 4 beats accepted. With MAC_CTRL_PERF_EN: perf_bubbles=3, perf_cycles=1+7+DRAIN_CYCLES+1.
- K=0 -> LOAD then DRAIN directly. op_ready never asserts. One result is delivered.
- res_ready held 0 for 10 cycles in OUT -> res_valid and res_data stable. A job_valid held during this time is not accepted until 1 cycle after the handshake.
- rst_n=0 for 1 cycle mid-STREAM (after 2 of 4 beats) -> next cycle: IDLE, job_ready=1, busy=0, res_valid=0, arr_* zero. A fresh K=2 job then completes normally.
- Back-to-back jobs K=1 then K=3 with job_valid held high -> second job accepted 1 cycle after the first result handshake. Second LOAD shows arr_num=3.
